// File: rtl/fft_butterfly_sequencer.sv
// Non-pipelined butterfly sequencer: drives an external DIT AGU, reads operand
// pairs from the ping-pong read bank and writes butterfly results to the other bank.
module fft_butterfly_sequencer #(
  parameter int unsigned MAX_N      = 32,
  parameter int unsigned ADDR_WIDTH = $clog2(MAX_N),
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BF_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   N,
  input  logic [ADDR_WIDTH-1:0] agu_idx_a,
  input  logic [ADDR_WIDTH-1:0] agu_idx_b,
  input  logic [ADDR_WIDTH-1:0] agu_k,
  input  logic                  agu_done_stage,
  input  logic                  agu_done_fft,
  output logic                  agu_next_step,
  output logic                  agu_reset_n,
  output logic                  rd_bank,
  output logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [ADDR_WIDTH-1:0] rd_addr_b,
  input  logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  bf_valid_in,
  output logic [DATA_WIDTH-1:0] bf_a,
  output logic [DATA_WIDTH-1:0] bf_b,
  output logic [ADDR_WIDTH-1:0] bf_k,
  input  logic                  bf_valid_out,
  input  logic [DATA_WIDTH-1:0] bf_y0,
  input  logic [DATA_WIDTH-1:0] bf_y1,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr_a,
  output logic [ADDR_WIDTH-1:0] wr_addr_b,
  output logic [DATA_WIDTH-1:0] wr_data_a,
  output logic [DATA_WIDTH-1:0] wr_data_b,
  output logic                  busy,
  output logic                  done,
  output logic                  result_bank,
  output logic                  error
);

  localparam int unsigned NW = ADDR_WIDTH + 1;

  if (BF_LATENCY < 1) begin : g_bad_latency
    $error("BF_LATENCY must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE, CLEAR, ISSUE, CAPTURE, WAIT_BF, WRITE, CHECK, DONE
  } state_t;

  state_t                state, state_nxt;
  logic [NW-1:0]         n_reg, n_nxt;
  logic                  n_ok;
  logic [ADDR_WIDTH-1:0] addr_mask;
  logic                  agu_next_step_nxt, agu_reset_n_nxt, rd_bank_nxt;
  logic                  bf_valid_in_nxt, wr_en_nxt;
  logic [ADDR_WIDTH-1:0] bf_k_nxt, wr_addr_a_nxt, wr_addr_b_nxt;
  logic [DATA_WIDTH-1:0] wr_data_a_nxt, wr_data_b_nxt;
  logic                  busy_nxt, done_nxt, result_bank_nxt, error_nxt;

  // Sizes accepted at runtime: powers of two from 4 up to MAX_N
  assign n_ok = (N >= NW'(4)) && (N <= NW'(MAX_N)) && ((N & (N - NW'(1))) == NW'(0));
  assign addr_mask = ADDR_WIDTH'(n_reg - NW'(1));

  // Read addresses come straight from the AGU; RAM data arrives one cycle later
  assign rd_addr_a = agu_idx_a;
  assign rd_addr_b = agu_idx_b;
  assign bf_a      = rd_data_a;
  assign bf_b      = rd_data_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      n_reg         <= '0;
      agu_next_step <= 1'b0;
      agu_reset_n   <= 1'b0;
      rd_bank       <= 1'b0;
      bf_valid_in   <= 1'b0;
      bf_k          <= '0;
      wr_en         <= 1'b0;
      wr_addr_a     <= '0;
      wr_addr_b     <= '0;
      wr_data_a     <= '0;
      wr_data_b     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      result_bank   <= 1'b0;
      error         <= 1'b0;
    end else begin
      state         <= state_nxt;
      n_reg         <= n_nxt;
      agu_next_step <= agu_next_step_nxt;
      agu_reset_n   <= agu_reset_n_nxt;
      rd_bank       <= rd_bank_nxt;
      bf_valid_in   <= bf_valid_in_nxt;
      bf_k          <= bf_k_nxt;
      wr_en         <= wr_en_nxt;
      wr_addr_a     <= wr_addr_a_nxt;
      wr_addr_b     <= wr_addr_b_nxt;
      wr_data_a     <= wr_data_a_nxt;
      wr_data_b     <= wr_data_b_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      result_bank   <= result_bank_nxt;
      error         <= error_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    n_nxt             = n_reg;
    agu_next_step_nxt = 1'b0;
    agu_reset_n_nxt   = 1'b1;
    rd_bank_nxt       = rd_bank;
    bf_valid_in_nxt   = 1'b0;
    bf_k_nxt          = bf_k;
    wr_en_nxt         = 1'b0;
    wr_addr_a_nxt     = wr_addr_a;
    wr_addr_b_nxt     = wr_addr_b;
    wr_data_a_nxt     = wr_data_a;
    wr_data_b_nxt     = wr_data_b;
    busy_nxt          = busy;
    done_nxt          = done;
    result_bank_nxt   = result_bank;
    error_nxt         = 1'b0;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          if (n_ok) begin
            n_nxt           = N;
            rd_bank_nxt     = 1'b0;
            busy_nxt        = 1'b1;
            done_nxt        = 1'b0;
            agu_reset_n_nxt = 1'b0;
            state_nxt       = CLEAR;
          end else begin
            error_nxt = 1'b1;
          end
        end
      end
      CLEAR: state_nxt = ISSUE;
      ISSUE: begin
        wr_addr_a_nxt   = agu_idx_a & addr_mask;
        wr_addr_b_nxt   = agu_idx_b & addr_mask;
        bf_k_nxt        = agu_k;
        bf_valid_in_nxt = 1'b1;
        state_nxt       = CAPTURE;
      end
      CAPTURE: state_nxt = WAIT_BF;
      WAIT_BF: begin
        if (bf_valid_out) begin
          wr_data_a_nxt     = bf_y0;
          wr_data_b_nxt     = bf_y1;
          wr_en_nxt         = 1'b1;
          agu_next_step_nxt = 1'b1;
          state_nxt         = WRITE;
        end
      end
      WRITE: state_nxt = CHECK;
      CHECK: begin
        // AGU flags were registered on the next_step edge and are valid here
        if (agu_done_fft) begin
          result_bank_nxt = ~rd_bank;
          done_nxt        = 1'b1;
          busy_nxt        = 1'b0;
          state_nxt       = DONE;
        end else begin
          if (agu_done_stage) rd_bank_nxt = ~rd_bank;
          state_nxt = ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fft_butterfly_sequencer.sv
// Directed bench for fft_butterfly_sequencer with behavioural AGU, ping-pong RAM
// and a two-cycle sum/difference butterfly.
module tb_fft_butterfly_sequencer;

  localparam int unsigned MAX_N = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 16;
  localparam int unsigned LAT   = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   n_in = '0;
  logic [AW-1:0] agu_idx_a, agu_idx_b, agu_k;
  logic          agu_done_stage, agu_done_fft;
  logic          agu_next_step, agu_reset_n, rd_bank;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic          bf_valid_in;
  logic [DW-1:0] bf_a, bf_b;
  logic [AW-1:0] bf_k;
  logic          bf_valid_out;
  logic [DW-1:0] bf_y0, bf_y1;
  logic          wr_en;
  logic [AW-1:0] wr_addr_a, wr_addr_b;
  logic [DW-1:0] wr_data_a, wr_data_b;
  logic          busy, done, result_bank, error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fft_butterfly_sequencer #(
    .MAX_N(MAX_N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BF_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .N(n_in),
    .agu_idx_a(agu_idx_a), .agu_idx_b(agu_idx_b), .agu_k(agu_k),
    .agu_done_stage(agu_done_stage), .agu_done_fft(agu_done_fft),
    .agu_next_step(agu_next_step), .agu_reset_n(agu_reset_n),
    .rd_bank(rd_bank), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .bf_valid_in(bf_valid_in), .bf_a(bf_a), .bf_b(bf_b), .bf_k(bf_k),
    .bf_valid_out(bf_valid_out), .bf_y0(bf_y0), .bf_y1(bf_y1),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
    .busy(busy), .done(done), .result_bank(result_bank), .error(error)
  );

  // DIT AGU model: stage s, butterfly j; flags registered on the next_step edge
  int agu_n = 4;
  int agu_s = 0;
  int agu_j = 0;
  always @(posedge clk) begin
    if (!agu_reset_n) begin
      agu_s <= 0; agu_j <= 0; agu_done_stage <= 1'b0; agu_done_fft <= 1'b0;
    end else begin
      agu_done_stage <= 1'b0;
      if (agu_next_step) begin
        if (agu_j == agu_n / 2 - 1) begin
          agu_j <= 0;
          agu_done_stage <= 1'b1;
          if ((2 << agu_s) >= agu_n) agu_done_fft <= 1'b1;
          else agu_s <= agu_s + 1;
        end else begin
          agu_j <= agu_j + 1;
        end
      end
    end
  end

  always_comb begin : agu_comb
    int half, a;
    half = 1 << agu_s;
    a = (agu_j / half) * 2 * half + agu_j % half;
    agu_idx_a = AW'(a);
    agu_idx_b = AW'(a + half);
    agu_k     = AW'((agu_j % half) * (agu_n / (2 * half)));
  end

  // Butterfly model: y0 = a + b, y1 = a - b, two-cycle latency
  logic          v1 = 1'b0;
  logic [DW-1:0] y0_1, y1_1;
  always @(posedge clk) begin
    v1 <= bf_valid_in; y0_1 <= bf_a + bf_b; y1_1 <= bf_a - bf_b;
    bf_valid_out <= v1; bf_y0 <= y0_1; bf_y1 <= y1_1;
  end

  // Ping-pong RAM: synchronous read from rd_bank, writes into ~rd_bank
  logic [DW-1:0] mem0 [MAX_N];
  logic [DW-1:0] mem1 [MAX_N];
  logic [DW-1:0] init_mem [MAX_N];
  logic          load = 1'b0;
  always @(posedge clk) begin
    rd_data_a <= rd_bank ? mem1[rd_addr_a] : mem0[rd_addr_a];
    rd_data_b <= rd_bank ? mem1[rd_addr_b] : mem0[rd_addr_b];
    if (load) begin
      for (int i = 0; i < MAX_N; i++) begin
        mem0[i] <= init_mem[i];
        mem1[i] <= '0;
      end
    end else if (wr_en) begin
      if (rd_bank) begin
        mem0[wr_addr_a] <= wr_data_a; mem0[wr_addr_b] <= wr_data_b;
      end else begin
        mem1[wr_addr_a] <= wr_data_a; mem1[wr_addr_b] <= wr_data_b;
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference in-place radix-2 DIT over a software ping-pong pair
  logic [DW-1:0] ref_mem [2][MAX_N];
  int            ref_bank;
  task automatic build_ref(input int n);
    int b, half, a, bb;
    logic [DW-1:0] x, y;
    b = 0;
    for (int i = 0; i < n; i++) ref_mem[0][i] = init_mem[i];
    for (int s = 0; (1 << s) < n; s++) begin
      half = 1 << s;
      for (int j = 0; j < n / 2; j++) begin
        a  = (j / half) * 2 * half + j % half;
        bb = a + half;
        x = ref_mem[b][a]; y = ref_mem[b][bb];
        ref_mem[1 - b][a]  = x + y;
        ref_mem[1 - b][bb] = x - y;
      end
      b = 1 - b;
    end
    ref_bank = b;
  endtask

  task automatic check_spectrum(input int n, input string tag);
    int bad;
    logic [DW-1:0] got;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      got = result_bank ? mem1[i] : mem0[i];
      if (got !== ref_mem[ref_bank][i]) bad++;
    end
    check(tag, bad, 0);
  endtask

  // Per-run observations; done_edge is the edge (start edge = 0) that first samples done=1
  int            r_done_edge, r_writes, r_toggles, r_rst_lows, r_viol, r_errs;
  logic [DW-1:0] f_a, f_b;
  logic [AW-1:0] f_k;
  logic [AW-1:0] w_a [4];
  logic [AW-1:0] w_b [4];
  logic          w_bank [4];

  task automatic run_fft(input int n, input bit hammer);
    bit prev_bank, seen_bf;
    @(negedge clk);
    for (int i = 0; i < MAX_N; i++) init_mem[i] = DW'(i * 97 + n * 13 + 1);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    build_ref(n);
    agu_n = n;
    n_in  = (AW + 1)'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    r_done_edge = -1; r_writes = 0; r_toggles = 0; r_rst_lows = 0; r_viol = 0; r_errs = 0;
    seen_bf = 1'b0;
    prev_bank = rd_bank;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (done) begin
        r_done_edge = cyc + 1;
        break;
      end
      if (rd_bank != prev_bank) r_toggles++;
      prev_bank = rd_bank;
      if (!agu_reset_n) r_rst_lows++;
      if (error) r_errs++;
      if (wr_en) begin
        if (r_writes < 4) begin
          w_a[r_writes] = wr_addr_a; w_b[r_writes] = wr_addr_b; w_bank[r_writes] = ~rd_bank;
        end
        r_writes++;
      end
      if (bf_valid_in && !seen_bf) begin
        f_a = bf_a; f_b = bf_b; f_k = bf_k; seen_bf = 1'b1;
      end
      if ((bf_valid_in && (wr_en || agu_next_step)) || (wr_en != agu_next_step)) r_viol++;
      start = hammer && (cyc % 9 == 4);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    int cnt;
    int v_bad [2];
    v_bad[0] = 12;
    v_bad[1] = 64;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_bf_valid_in", bf_valid_in, 0);
    check("rst_next_step", agu_next_step, 0);
    check("rst_agu_reset_n", agu_reset_n, 0);
    check("rst_rd_bank", rd_bank, 0);
    check("rst_error", error, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_agu_reset_n", agu_reset_n, 1);

    // Invalid sizes (64 truncates to 0 on the 6-bit port) must be rejected
    foreach (v_bad[i]) begin
      n_in  = (AW + 1)'(v_bad[i]);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check($sformatf("bad_n%0d_error", v_bad[i]), error, 1);
      check($sformatf("bad_n%0d_busy", v_bad[i]), busy, 0);
      check($sformatf("bad_n%0d_agu_reset_n", v_bad[i]), agu_reset_n, 1);
      @(negedge clk);
      check($sformatf("bad_n%0d_error_pulse", v_bad[i]), error, 0);
      check($sformatf("bad_n%0d_still_idle", v_bad[i]), busy, 0);
    end

    run_fft(8, 1'b0);
    check("n8_done_edge", r_done_edge, 74);
    check("n8_writes", r_writes, 12);
    check("n8_agu_reset_cycles", r_rst_lows, 1);
    check("n8_toggles", r_toggles, 2);
    check("n8_result_bank", result_bank, 1);
    check("n8_busy_at_done", busy, 0);
    check("n8_strobes", r_viol, 0);
    check_spectrum(8, "n8_spectrum");

    // Invalid start while DONE: error pulse, stay done
    n_in  = (AW + 1)'(12);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_bad_error", error, 1);
    check("done_bad_done", done, 1);
    check("done_bad_busy", busy, 0);

    run_fft(4, 1'b0);
    check("n4_done_edge", r_done_edge, 26);
    check("n4_writes", r_writes, 4);
    check("n4_bf_a", f_a, init_mem[0]);
    check("n4_bf_b", f_b, init_mem[1]);
    check("n4_bf_k", f_k, 0);
    check("n4_w0_addr_a", w_a[0], 0);
    check("n4_w0_addr_b", w_b[0], 1);
    check("n4_w0_bank", w_bank[0], 1);
    check("n4_w1_addr_a", w_a[1], 2);
    check("n4_w1_addr_b", w_b[1], 3);
    check("n4_w1_bank", w_bank[1], 1);
    check("n4_w2_bank", w_bank[2], 0);
    check("n4_toggles", r_toggles, 1);
    check("n4_result_bank", result_bank, 0);
    check_spectrum(4, "n4_spectrum");

    run_fft(32, 1'b0);
    check("n32_writes", r_writes, 80);
    check("n32_toggles", r_toggles, 4);
    check("n32_done_edge", r_done_edge, 482);
    check("n32_result_bank", result_bank, 1);
    check("n32_strobes", r_viol, 0);
    check_spectrum(32, "n32_spectrum");

    run_fft(8, 1'b1);
    check("n8h_writes", r_writes, 12);
    check("n8h_done_edge", r_done_edge, 74);
    check("n8h_no_error", r_errs, 0);
    check("n8h_agu_reset_cycles", r_rst_lows, 1);
    check_spectrum(8, "n8h_spectrum");

    // Reset during WAIT_BF of an N=16 run
    agu_n = 16;
    n_in  = (AW + 1)'(16);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (bf_valid_in) cnt++;
      if (cnt == 3) break;
      @(negedge clk);
    end
    check("rst16_reached_capture", cnt, 3);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst16_wr_en", wr_en, 0);
    check("rst16_busy", busy, 0);
    check("rst16_agu_reset_n", agu_reset_n, 0);
    check("rst16_bf_valid_in", bf_valid_in, 0);
    check("rst16_next_step", agu_next_step, 0);
    check("rst16_done", done, 0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (wr_en) cnt++;
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (wr_en) cnt++;
    end
    check("rst16_no_writes", cnt, 0);
    check("rst16_idle_busy", busy, 0);

    run_fft(4, 1'b0);
    check("post_rst_writes", r_writes, 4);
    check("post_rst_done_edge", r_done_edge, 26);
    check("post_rst_result_bank", result_bank, 0);
    check_spectrum(4, "post_rst_spectrum");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
